// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty decodes, sticky overflow/underflow and optional FWFT read.
// Flags follow count 1 cycle after an accepted push/pop; push while full and pop while empty are dropped and flagged.
module sync_fifo_flags #(
    parameter int DWIDTH   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     push,
    input  logic [DWIDTH-1:0]        wdata,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     pop,
    output logic [DWIDTH-1:0]        rdata,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              push_acc, pop_acc;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    assign push_acc = push & ~full;
    assign pop_acc  = pop & ~empty;

    always_comb begin
        wptr_d  = wptr_q + AW'(push_acc);
        rptr_d  = rptr_q + AW'(pop_acc);
        count_d = count_q + CW'(push_acc) - CW'(pop_acc);
        // A new rejection in the same cycle takes priority over the clear.
        ovf_d   = (push & full)  | (ovf_q & ~clr_err);
        unf_d   = (pop  & empty) | (unf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = mem_q[rptr_q];
        end else begin : g_std
            logic [DWIDTH-1:0] rdata_q;
            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    rdata_q <= '0;
                end else if (pop_acc) begin
                    rdata_q <= mem_q[rptr_q];
                end
            end
            assign rdata = rdata_q;
        end
    endgenerate
endmodule
